// File: rtl/tetris_pkg.sv
// Shared board geometry, cell codes and arbiter state encoding for the playfield RAM.
package tetris_pkg;

    typedef logic [2:0] cell_code_t;

    localparam int unsigned BOARD_X0    = 240;
    localparam int unsigned BOARD_Y0    = 80;
    localparam int unsigned COLS        = 10;
    localparam int unsigned ROWS        = 20;
    localparam int unsigned CELL_LOG2   = 4;
    localparam int unsigned BOARD_CELLS = COLS * ROWS;
    localparam cell_code_t  EMPTY_CODE  = 3'b111;

    localparam int unsigned CELL_PX = 1 << CELL_LOG2;

    // Pixel-space limits as 10-bit values so they compare directly against DrawX/DrawY.
    localparam logic [9:0] WIN_X0      = 10'(BOARD_X0);
    localparam logic [9:0] WIN_X_END   = 10'(BOARD_X0 + COLS * CELL_PX);
    localparam logic [9:0] WIN_Y0      = 10'(BOARD_Y0);
    localparam logic [9:0] WIN_Y_END   = 10'(BOARD_Y0 + ROWS * CELL_PX);
    localparam logic [9:0] SLOT_X0     = 10'(BOARD_X0 - CELL_PX);
    localparam logic [9:0] SLOT_X_LAST = 10'(BOARD_X0 + (COLS - 2) * CELL_PX);
    localparam logic [9:0] SWAP_X_LAST = 10'(BOARD_X0 + (COLS - 1) * CELL_PX);

    localparam logic [7:0] LAST_CELL   = 8'(BOARD_CELLS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    function automatic logic cell_in_range(input logic [7:0] addr);
        return addr < 8'(BOARD_CELLS);
    endfunction

endpackage

// File: rtl/board_addr_gen.sv
// Cell index from row/column using shifts and adds: row*10 + col.
module board_addr_gen (
    input  logic [4:0] row,
    input  logic [3:0] col,
    output logic [7:0] addr
);

    assign addr = {row, 3'b000} + {2'b00, row, 1'b0} + {4'b0000, col};

endmodule

// File: rtl/board_display_arbiter.sv
// Shares the single-port board RAM between fixed display read slots, the clear engine
// and game-logic accesses; produces the registered cell code for the colour mapper.
module board_display_arbiter
    import tetris_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [3:0] pixel,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    input  logic [2:0] ram_rdata,
    input  logic       gl_req,
    input  logic       gl_we,
    input  logic [7:0] gl_addr,
    input  logic [2:0] gl_wdata,
    output logic       gl_ack,
    output logic       gl_rvalid,
    output logic [2:0] gl_rdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output arb_state_e dbg_state
);

    arb_state_e state_q, state_d;
    logic [7:0] clr_idx_q, clr_idx_d;
    logic [9:0] DrawX_q, DrawX_d;
    cell_code_t next_code_q, next_code_d;
    cell_code_t current_code_q, current_code_d;
    logic [3:0] pixel_q, pixel_d;
    logic       rd_pending_q, rd_pending_d;
    logic       gl_rvalid_q, gl_rvalid_d;
    logic       oor_q, oor_d;

    logic       boundary, row_in_board, display_slot, swap, in_window;
    logic [9:0] y_off, x_off;
    logic [4:0] disp_row;
    logic [3:0] disp_col;
    logic [7:0] disp_addr;

    always_comb begin
        boundary     = (DrawX != DrawX_q) && (DrawX[CELL_LOG2-1:0] == '0);
        row_in_board = (DrawY >= WIN_Y0) && (DrawY < WIN_Y_END);
        y_off        = DrawY - WIN_Y0;
        x_off        = DrawX - SLOT_X0;
        disp_row     = 5'(y_off >> CELL_LOG2);
        disp_col     = 4'(x_off >> CELL_LOG2);
        // Column c is fetched one cell early so it is ready when the beam reaches it.
        display_slot = boundary && row_in_board && (DrawX >= SLOT_X0) && (DrawX <= SLOT_X_LAST);
        swap         = boundary && (DrawX >= WIN_X0) && (DrawX <= SWAP_X_LAST);
        in_window    = row_in_board && (DrawX >= WIN_X0) && (DrawX < WIN_X_END);
    end

    board_addr_gen u_addr_gen (
        .row  (disp_row),
        .col  (disp_col),
        .addr (disp_addr)
    );

    // Game handshake: gl_req/gl_we/gl_addr/gl_wdata are held by the requester until it
    // sees gl_ack, which is combinational and marks the cycle the RAM access is issued;
    // a request still high in the following cycle is a new access.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        gl_ack       = 1'b0;
        gl_rvalid_d  = 1'b0;
        oor_d        = 1'b0;
        rd_pending_d = 1'b0;
        if (!Reset) begin
            if (display_slot) begin
                ram_addr     = disp_addr;
                rd_pending_d = 1'b1;
            end else if (state_q == ST_CLEAR) begin
                ram_addr  = clr_idx_q;
                ram_we    = 1'b1;
                ram_wdata = EMPTY_CODE;
                clr_idx_d = clr_idx_q + 8'd1;
                if (clr_idx_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                end
            end else if (gl_req) begin
                ram_addr    = gl_addr;
                ram_we      = gl_we && cell_in_range(gl_addr);
                ram_wdata   = gl_wdata;
                gl_ack      = 1'b1;
                gl_rvalid_d = !gl_we;
                oor_d       = !cell_in_range(gl_addr);
            end
            if ((state_q == ST_IDLE) && clear_start) begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        end
    end

    always_comb begin
        DrawX_d        = DrawX;
        next_code_d    = rd_pending_q ? ram_rdata : next_code_q;
        current_code_d = swap ? next_code_q : current_code_q;
        pixel_d        = in_window ? {1'b0, current_code_d} : {1'b0, EMPTY_CODE};
        gl_rdata       = gl_rvalid_q ? (oor_q ? EMPTY_CODE : ram_rdata) : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            clr_idx_q      <= '0;
            DrawX_q        <= '0;
            next_code_q    <= EMPTY_CODE;
            current_code_q <= EMPTY_CODE;
            pixel_q        <= {1'b0, EMPTY_CODE};
            rd_pending_q   <= 1'b0;
            gl_rvalid_q    <= 1'b0;
            oor_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            DrawX_q        <= DrawX_d;
            next_code_q    <= next_code_d;
            current_code_q <= current_code_d;
            pixel_q        <= pixel_d;
            rd_pending_q   <= rd_pending_d;
            gl_rvalid_q    <= gl_rvalid_d;
            oor_q          <= oor_d;
        end
    end

    assign pixel      = pixel_q;
    assign gl_rvalid  = gl_rvalid_q;
    assign clear_busy = (state_q == ST_CLEAR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_board_display_arbiter.sv
// Randomized bench for board_display_arbiter against a playfield-level reference model.
module tb_board_display_arbiter;
    import tetris_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic [3:0] pixel;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;
    logic       gl_req, gl_we;
    logic [7:0] gl_addr;
    logic [2:0] gl_wdata;
    logic       gl_ack, gl_rvalid;
    logic [2:0] gl_rdata;
    logic       clear_start, clear_busy;
    arb_state_e dbg_state;

    always #5 Clk = ~Clk;

    board_display_arbiter dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .pixel(pixel),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_ack(gl_ack), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .dbg_state(dbg_state)
    );

    logic [4:0] ag_row;
    logic [3:0] ag_col;
    logic [7:0] ag_addr;
    board_addr_gen u_ag (.row(ag_row), .col(ag_col), .addr(ag_addr));

    // External synchronous board RAM.
    logic [2:0] mem [0:255];
    always @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference playfield and scoreboard.
    cell_code_t ref_board [0:199];
    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int oor_wr   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] exp_pixel(input logic [9:0] x, input logic [9:0] y);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        if (yi >= int'(BOARD_Y0) && yi < int'(BOARD_Y0) + 16 * int'(ROWS) &&
            xi >= int'(BOARD_X0) && xi < int'(BOARD_X0) + 16 * int'(COLS))
            return {1'b0, ref_board[((yi - int'(BOARD_Y0)) / 16) * int'(COLS) + (xi - int'(BOARD_X0)) / 16]};
        return 4'h7;
    endfunction

    // Monitors: pixel lags the sampled DrawX/DrawY by one clock; rvalid follows a read ack.
    logic       pix_en = 1'b0, mon_en = 1'b0, s_en = 1'b0, exp_rv = 1'b0;
    logic [9:0] sx = '0, sy = '0;
    always @(posedge Clk) begin
        sx   <= DrawX;
        sy   <= DrawY;
        s_en <= pix_en;
    end
    always @(negedge Clk) begin
        if (s_en && pix_en) check("pixel", pixel, exp_pixel(sx, sy));
        if (mon_en) begin
            check("rvalid", gl_rvalid, exp_rv);
            if (gl_rvalid) begin
                if (exp_q.size() > 0) check("rdata", gl_rdata, exp_q.pop_front());
                else check("rdata_avail", exp_q.size(), 1);
            end
            if (ram_we && ram_addr >= 8'd200) oor_wr <= oor_wr + 1;
            exp_rv <= gl_ack && !gl_we;
        end else begin
            exp_rv <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic gl_access(input logic we, input logic [7:0] addr, input logic [2:0] data);
        int   waited = 0;
        logic got = 1'b0;
        gl_req = 1'b1; gl_we = we; gl_addr = addr; gl_wdata = data;
        while (!got && waited < 300) begin
            @(negedge Clk);
            if (gl_ack) got = 1'b1;
            else waited++;
        end
        check("ack_seen", got, 1);
        if (got) begin
            check("ack_addr", ram_addr, addr);
            check("ack_we", ram_we, we && addr < 8'd200);
            if (we && addr < 8'd200) check("ack_wdata", ram_wdata, data);
            if (!we) exp_q.push_back(addr < 8'd200 ? ref_board[addr] : EMPTY_CODE);
            else if (addr < 8'd200) ref_board[addr] = data;
        end
        tick();
        gl_req = 1'b0;
    endtask

    task automatic sweep_line(input int y, input int x0, input int x1);
        DrawY = 10'(y);
        for (int x = x0; x <= x1; x++) begin
            DrawX = 10'(x);
            repeat ($urandom_range(1, 2)) tick();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ys [9] = '{60, 79, 80, 95, 96, 150, 250, 399, 400};
        logic sweep_done;
        int   busy_cnt, guard, cnt;
        logic acked;

        for (int i = 0; i < 200; i++) ref_board[i] = 3'b000;
        Reset = 1'b1; DrawX = 10'd224; DrawY = 10'd80; clear_start = 1'b0;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'd3; gl_wdata = 3'b001;

        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                ag_row = 5'(r); ag_col = 4'(c);
                #1 check("addr_gen", ag_addr, r * 10 + c);
            end

        // Reset held with a pending request and an active display slot position.
        repeat (3) @(negedge Clk);
        check("rst_pixel", pixel, 4'h7);
        check("rst_ack", gl_ack, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_rvalid", gl_rvalid, 0);
        check("rst_rdata", gl_rdata, 0);
        check("rst_state", dbg_state, ST_IDLE);

        // Mid-line reset: run part of a line, then reset again.
        Reset = 1'b0; gl_req = 1'b0;
        sweep_line(80, 220, 260);
        @(negedge Clk);
        Reset = 1'b1; gl_req = 1'b1; gl_we = 1'b0;
        #1;
        check("midrst_pixel", pixel, 4'h7);
        check("midrst_ack", gl_ack, 0);
        check("midrst_busy", clear_busy, 0);
        @(negedge Clk);
        Reset = 1'b0; gl_req = 1'b0; DrawY = 10'd0;
        #1;
        check("rel_pixel", pixel, 4'h7);
        check("rel_ack", gl_ack, 0);
        check("rel_busy", clear_busy, 0);
        @(negedge Clk);
        check("rel_pixel2", pixel, 4'h7);
        tick();
        mon_en = 1'b1;

        // Fill the board, then random mixed traffic away from display slots.
        for (int i = 0; i < 200; i++) gl_access(1'b1, 8'(i), 3'($urandom_range(0, 7)));
        for (int i = 0; i < 40; i++)
            gl_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        gl_access(1'b1, 8'd0, 3'b011);
        gl_access(1'b1, 8'd1, 3'b101);

        // Directed first line: reads of cells 0 and 1 at X=224 and X=240.
        pix_en = 1'b1;
        DrawY = 10'd80; DrawX = 10'd223;
        tick(); tick();
        DrawX = 10'd224;
        @(negedge Clk);
        check("slot_addr0", ram_addr, 0);
        check("slot_we0", ram_we, 0);
        tick();
        for (int x = 225; x < 240; x++) begin DrawX = 10'(x); tick(); end
        DrawX = 10'd240;
        @(negedge Clk);
        check("slot_addr1", ram_addr, 1);
        tick();
        for (int x = 241; x < 272; x++) begin
            DrawX = 10'(x);
            tick();
            if (x == 245) check("pix_c0", pixel, 4'h3);
            if (x == 260) check("pix_c1", pixel, 4'h5);
        end

        // Randomized sweeps with concurrent reads and suppressed out-of-range writes.
        sweep_done = 1'b0;
        fork
            begin
                foreach (ys[i]) sweep_line(ys[i], 200, 410);
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if ($urandom_range(0, 3) == 0)
                            gl_access(1'b1, 8'($urandom_range(200, 255)), 3'($urandom_range(0, 7)));
                        else
                            gl_access(1'b0, 8'($urandom_range(0, 255)), 3'b000);
                    end else begin
                        tick();
                    end
                end
            end
        join
        pix_en = 1'b0;

        // Request raised on the same cycle as a display slot.
        DrawY = 10'd80; DrawX = 10'd255;
        tick();
        DrawX = 10'd256; gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'd15; gl_wdata = 3'b010;
        @(negedge Clk);
        check("slot_no_ack", gl_ack, 0);
        check("slot_first_addr", ram_addr, 2);
        check("slot_no_we", ram_we, 0);
        @(negedge Clk);
        check("late_ack", gl_ack, 1);
        check("late_addr", ram_addr, 15);
        check("late_we", ram_we, 1);
        ref_board[15] = 3'b010;
        tick();
        gl_req = 1'b0; DrawY = 10'd0;
        tick();
        check("cell15", mem[15], 3'b010);

        gl_access(1'b0, 8'd250, 3'b000);
        gl_access(1'b1, 8'd230, 3'b101);
        gl_access(1'b0, 8'd15, 3'b000);
        tick();

        // Clear with a simultaneous game write, then a read held through the clear.
        clear_start = 1'b1; gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'd7; gl_wdata = 3'b100;
        @(negedge Clk);
        check("cs_ack", gl_ack, 1);
        check("cs_busy", clear_busy, 0);
        tick();
        clear_start = 1'b0; gl_we = 1'b0; gl_addr = 8'd5;
        for (int i = 0; i < 200; i++) ref_board[i] = EMPTY_CODE;
        busy_cnt = 0; acked = 1'b0; guard = 0;
        while (!acked && guard < 1000) begin
            @(negedge Clk);
            guard++;
            if (clear_busy) busy_cnt++;
            if (gl_ack) begin
                check("held_ack_busy", clear_busy, 0);
                exp_q.push_back(ref_board[5]);
                acked = 1'b1;
            end
        end
        check("held_acked", acked, 1);
        check("busy_cycles", busy_cnt, 200);
        tick();
        gl_req = 1'b0;
        tick();
        for (int i = 0; i < 200; i++) check("cleared", mem[i], EMPTY_CODE);

        // Clear interrupted: ignored second pulse, then reset after 120 cells.
        for (int i = 0; i < 200; i++) gl_access(1'b1, 8'(i), 3'($urandom_range(0, 6)));
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 120 && guard < 400) begin
            @(negedge Clk);
            guard++;
            if (clear_busy) cnt++;
            tick();
            clear_start = (cnt == 50);
        end
        clear_start = 1'b0;
        check("clr_cnt", cnt, 120);
        mon_en = 1'b0;
        Reset = 1'b1;
        #1;
        check("irst_busy", clear_busy, 0);
        check("irst_state", dbg_state, ST_IDLE);
        check("irst_we", ram_we, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_busy", clear_busy, 0);
        for (int i = 0; i < 120; i++) ref_board[i] = EMPTY_CODE;
        for (int i = 0; i < 200; i++) check("partial", mem[i], ref_board[i]);

        check("oor_writes", oor_wr, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
